// File: rtl/idu_stage_if.sv
// ----------------------------------------------------------------------------
// idu_stage_if
// Handshake and bus bundle between the fetch unit, the decode stage and the
// execute unit.
//
// Parameters:
//   XLEN     datapath width (32 or 64)
//   WMASK_W  store byte-mask width, always XLEN/8
//
// Signal groups:
//   flush                      redirect from EXU, drops everything held
//   in_valid/in_ready          IFU -> IDU handshake
//   in_inst, in_pc             fetched instruction and its PC
//   out_valid/out_ready        IDU -> EXU handshake
//   out_*                      decoded fields, immediate and control signals
//
// Modports:
//   master  the environment side (drives inputs, consumes decoded entries)
//   slave   the decode stage itself
// ----------------------------------------------------------------------------
interface idu_stage_if #(
  parameter int XLEN = 64
);
  localparam int WMASK_W = XLEN / 8;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_inst;
  logic [XLEN-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [5:0]         out_inst_now;
  logic [4:0]         out_rs1;
  logic [4:0]         out_rs2;
  logic [4:0]         out_rd;
  logic [XLEN-1:0]    out_imm;
  logic               out_reg_write;
  logic               out_src1_is_pc;
  logic               out_src2_is_imm;
  logic               out_mem_write_en;
  logic               out_mem_read_en;
  logic [WMASK_W-1:0] out_wmask;
  logic               out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_inst_now, out_rs1, out_rs2, out_rd,
           out_imm, out_reg_write, out_src1_is_pc, out_src2_is_imm,
           out_mem_write_en, out_mem_read_en, out_wmask, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_inst_now, out_rs1, out_rs2, out_rd,
           out_imm, out_reg_write, out_src1_is_pc, out_src2_is_imm,
           out_mem_write_en, out_mem_read_en, out_wmask, out_illegal
  );
endinterface

// File: rtl/idu_stage.sv
// ----------------------------------------------------------------------------
// idu_stage
// Registered instruction-decode stage between IFU and EXU. Decodes an RV32I /
// RV64I base subset into an instruction ID, register fields, a sign-extended
// immediate and control signals, presenting them one cycle after acceptance.
// A one-entry skid register keeps full throughput under back-pressure.
//
// Ports:
//   clock   core clock
//   reset   synchronous, active-high; discards both entries, zeroes outputs
//   bus     idu_stage_if.slave (flush, in_* handshake, out_* handshake/data)
//
// Optional feature macro: IDU_STAGE_ILLEGAL_TRAP_EN
//   defined   unknown encodings raise out_illegal and halt intake until
//             flush or reset (held entries still drain)
//   undefined out_illegal is 0, unknown encodings decode as a NOP
// ----------------------------------------------------------------------------
module idu_stage #(
  parameter int XLEN = 64
) (
  input  logic       clock,
  input  logic       reset,
  idu_stage_if.slave bus
);

  localparam int WMASK_W = XLEN / 8;
  localparam bit IS64    = (XLEN == 64);

`ifdef IDU_STAGE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [5:0] INST_NONE  = 6'd0,  INST_LUI   = 6'd1,  INST_AUIPC = 6'd2,
                         INST_JAL   = 6'd3,  INST_JALR  = 6'd4,  INST_BEQ   = 6'd5,
                         INST_BNE   = 6'd6,  INST_LW    = 6'd7,  INST_LD    = 6'd8,
                         INST_LBU   = 6'd9,  INST_SB    = 6'd10, INST_SH    = 6'd11,
                         INST_SW    = 6'd12, INST_SD    = 6'd13, INST_ADDI  = 6'd14,
                         INST_SLTIU = 6'd15, INST_XORI  = 6'd16, INST_ORI   = 6'd17,
                         INST_ANDI  = 6'd18, INST_SLLI  = 6'd19, INST_SRLI  = 6'd20,
                         INST_SRAI  = 6'd21, INST_ADDIW = 6'd22, INST_ADD   = 6'd23,
                         INST_SUB   = 6'd24, INST_AND   = 6'd25, INST_OR    = 6'd26,
                         INST_ADDW  = 6'd27, INST_SUBW  = 6'd28, INST_EBREAK = 6'd29;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [5:0]         inst_now;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    imm;
    logic               reg_write;
    logic               src1_is_pc;
    logic               src2_is_imm;
    logic               mem_write_en;
    logic               mem_read_en;
    logic [WMASK_W-1:0] wmask;
    logic               illegal;
  } entry_t;

  entry_t          dec;
  entry_t          main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            halted_q, halted_d;
  logic            accept, drain;
  logic [5:0]      inst_now;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign bus.in_ready = !reset && !skid_valid_q && !halted_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = main_valid_q && bus.out_ready;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign funct7 = bus.in_inst[31:25];

  // Identify the instruction. Anything not matched stays INST_NONE, which the
  // control decode below treats as unknown. RV64-only encodings and the sixth
  // shamt bit are only accepted when XLEN is 64.
  always_comb begin
    inst_now = INST_NONE;
    case (opcode)
      7'b0110111: inst_now = INST_LUI;
      7'b0010111: inst_now = INST_AUIPC;
      7'b1101111: inst_now = INST_JAL;
      7'b1100111: if (funct3 == 3'b000) inst_now = INST_JALR;
      7'b1100011: begin
        if (funct3 == 3'b000)      inst_now = INST_BEQ;
        else if (funct3 == 3'b001) inst_now = INST_BNE;
      end
      7'b0000011: begin
        if (funct3 == 3'b010)              inst_now = INST_LW;
        else if (funct3 == 3'b011 && IS64) inst_now = INST_LD;
        else if (funct3 == 3'b100)         inst_now = INST_LBU;
      end
      7'b0100011: begin
        if (funct3 == 3'b000)              inst_now = INST_SB;
        else if (funct3 == 3'b001)         inst_now = INST_SH;
        else if (funct3 == 3'b010)         inst_now = INST_SW;
        else if (funct3 == 3'b011 && IS64) inst_now = INST_SD;
      end
      7'b0010011: begin
        case (funct3)
          3'b000: inst_now = INST_ADDI;
          3'b011: inst_now = INST_SLTIU;
          3'b100: inst_now = INST_XORI;
          3'b110: inst_now = INST_ORI;
          3'b111: inst_now = INST_ANDI;
          3'b001: if (funct7[6:1] == 6'b000000 && (IS64 || !funct7[0])) inst_now = INST_SLLI;
          3'b101: begin
            if (funct7[6:1] == 6'b000000 && (IS64 || !funct7[0]))      inst_now = INST_SRLI;
            else if (funct7[6:1] == 6'b010000 && (IS64 || !funct7[0])) inst_now = INST_SRAI;
          end
          default: inst_now = INST_NONE;
        endcase
      end
      7'b0011011: if (IS64 && funct3 == 3'b000) inst_now = INST_ADDIW;
      7'b0110011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000)      inst_now = INST_ADD;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) inst_now = INST_SUB;
        else if (funct7 == 7'b0000000 && funct3 == 3'b111) inst_now = INST_AND;
        else if (funct7 == 7'b0000000 && funct3 == 3'b110) inst_now = INST_OR;
      end
      7'b0111011: begin
        if (IS64 && funct3 == 3'b000 && funct7 == 7'b0000000)      inst_now = INST_ADDW;
        else if (IS64 && funct3 == 3'b000 && funct7 == 7'b0100000) inst_now = INST_SUBW;
      end
      7'b1110011: if (bus.in_inst == 32'h0010_0073) inst_now = INST_EBREAK;
      default: inst_now = INST_NONE;
    endcase
  end

  // Build the decoded entry. Immediates are filled with the sign bit first and
  // then the low bits are overwritten, which works for both XLEN values.
  always_comb begin
    imm_i = {XLEN{bus.in_inst[31]}};
    imm_i[11:0] = bus.in_inst[31:20];
    imm_s = {XLEN{bus.in_inst[31]}};
    imm_s[11:0] = {bus.in_inst[31:25], bus.in_inst[11:7]};
    imm_b = {XLEN{bus.in_inst[31]}};
    imm_b[12:0] = {bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
    imm_u = {XLEN{bus.in_inst[31]}};
    imm_u[31:0] = {bus.in_inst[31:12], 12'b0};
    imm_j = {XLEN{bus.in_inst[31]}};
    imm_j[20:0] = {bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20], bus.in_inst[30:21], 1'b0};

    dec          = '0;
    dec.pc       = bus.in_pc;
    dec.inst_now = inst_now;
    dec.rs1      = bus.in_inst[19:15];
    dec.rs2      = bus.in_inst[24:20];
    dec.rd       = bus.in_inst[11:7];
    case (inst_now)
      INST_LUI:   begin dec.imm = imm_u; dec.reg_write = 1'b1; dec.src2_is_imm = 1'b1; end
      INST_AUIPC, INST_JAL: begin
        dec.imm         = (inst_now == INST_JAL) ? imm_j : imm_u;
        dec.reg_write   = 1'b1;
        dec.src1_is_pc  = 1'b1;
        dec.src2_is_imm = 1'b1;
      end
      INST_JALR, INST_ADDI, INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI,
      INST_SLLI, INST_SRLI, INST_SRAI, INST_ADDIW: begin
        dec.imm = imm_i; dec.reg_write = 1'b1; dec.src2_is_imm = 1'b1;
      end
      INST_LW, INST_LD, INST_LBU: begin
        dec.imm = imm_i; dec.reg_write = 1'b1; dec.src2_is_imm = 1'b1; dec.mem_read_en = 1'b1;
      end
      INST_BEQ, INST_BNE: begin
        dec.imm = imm_b; dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1;
      end
      INST_SB, INST_SH, INST_SW, INST_SD: begin
        dec.imm          = imm_s;
        dec.src2_is_imm  = 1'b1;
        dec.mem_write_en = 1'b1;
        case (inst_now)
          INST_SB: dec.wmask = WMASK_W'(1);
          INST_SH: dec.wmask = WMASK_W'(3);
          INST_SW: dec.wmask = WMASK_W'(15);
          default: dec.wmask = '1;
        endcase
      end
      INST_ADD, INST_SUB, INST_AND, INST_OR, INST_ADDW, INST_SUBW: dec.reg_write = 1'b1;
      INST_EBREAK: dec.reg_write = 1'b0;
      default: dec.illegal = TRAP_EN;
    endcase
  end

  // Main/skid bookkeeping. When main frees up the skid entry moves over first,
  // so FIFO order holds; the skid only fills while main is stuck. Flush beats
  // every other update and also discards whatever is accepted this cycle.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    halted_d     = halted_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      halted_d     = 1'b0;
    end else begin
      if (!main_valid_q || drain) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = accept;
          if (accept) main_d = dec;
        end
      end else if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
      if (TRAP_EN && accept && dec.illegal) halted_d = 1'b1;
    end
  end

  // State registers; reset additionally zeroes the held data so the outputs
  // read all-zero while the stage is empty after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.out_valid        = main_valid_q;
  assign bus.out_pc           = main_q.pc;
  assign bus.out_inst_now     = main_q.inst_now;
  assign bus.out_rs1          = main_q.rs1;
  assign bus.out_rs2          = main_q.rs2;
  assign bus.out_rd           = main_q.rd;
  assign bus.out_imm          = main_q.imm;
  assign bus.out_reg_write    = main_q.reg_write;
  assign bus.out_src1_is_pc   = main_q.src1_is_pc;
  assign bus.out_src2_is_imm  = main_q.src2_is_imm;
  assign bus.out_mem_write_en = main_q.mem_write_en;
  assign bus.out_mem_read_en  = main_q.mem_read_en;
  assign bus.out_wmask        = main_q.wmask;
  assign bus.out_illegal      = main_q.illegal;

endmodule
